regfile_writer: RTL and testbench
=================================

# regfile_writer

Write-back port controller for the 32x32 two-read/one-write register file. It is the writer side of the register file's A3/WD3/WE3 port: it takes results from two producers, a single-cycle ALU path (port A) and a long-latency load/multiply path (port B), and issues at most one register write per cycle. Port B results are buffered in a small FIFO and drained in idle write slots, with a starvation guard. Writes to register 0 are discarded, because register 0 always reads as zero.

## Interface
Parameters:
- DEPTH, 4, port B FIFO entries (power of two, ≥2)
- STARVE_MAX, 8, consecutive lost arbitrations before the FIFO head is forced through (≥1)

Ports:
- CLK  input  1  system clock, all state on rising edge
- RESETN  input  1  asynchronous, active-low reset
- A_VALID  input  1  ALU result valid
- A_READY  output  1  ALU result accepted this cycle
- A_ADDR  input  5  ALU destination register
- A_DATA  input  32  ALU result
- B_VALID  input  1  load/multiply result valid
- B_READY  output  1  FIFO can accept
- B_ADDR  input  5  load/multiply destination register
- B_DATA  input  32  load/multiply result
- A3  output  5  register file write address
- WD3  output  32  register file write data
- WE3  output  1  register file write enable
- PENDING  output  32  bit r set while any FIFO entry targets register r (WB_PENDING_EN only)

## Operation
- Port A has priority by default. A_READY = 1 except in a forced-drain cycle.
- Port A is combinational to the write port. When A_VALID & A_READY: A3=A_ADDR, WD3=A_DATA, WE3=(A_ADDR!=0). The register is written on that same edge.
- Port B: B_READY = !full. On B_VALID & B_READY, {B_ADDR,B_DATA} is pushed at the edge. There is no same-cycle bypass, and pass-through is not allowed when full.
- Drain: when port A is not writing (A_VALID=0, or a forced-drain cycle) and the FIFO is non-empty, the head drives A3/WD3 and is popped at the edge.
  - WE3 = (head addr != 0). An addr-0 head is popped silently.
- Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and port A wins.
  - Clears on any pop, and whenever the FIFO is empty.
  - When the counter equals STARVE_MAX, the next cycle is forced-drain: A_READY=0, the head is written, and the counter clears.
- Idle (no A write, FIFO empty): WE3=0. A3 and WD3 hold the last driven values; they are don't-care.
- Ordering: FIFO entries are written in push order. Port A and port B are not mutually ordered; hazard control belongs to the issue logic, using PENDING.

## Timing
- Reset (RESETN=0, async): FIFO empty, pointers and starvation counter 0, WE3=0, A_READY=0, B_READY=0, PENDING=0, A3=0, WD3=0. WE3 is gated low for the whole time reset is asserted.
- The first cycle after deassertion: A_READY=1, B_READY=1.
- Port A latency is 0 cycles: accept and write happen on the same edge.
- Port B latency is at least 1 cycle: push at edge N, earliest write at edge N+1.
- Worst-case port B wait per entry is ≤ STARVE_MAX+1 cycles once it reaches the head.
- Full: B_READY=0 until a pop. A pop at edge N gives B_READY=1 in cycle N+1.
- Reset mid-operation discards all FIFO contents; no partial write is issued.

## Configuration
- REGFILE_WRITER_PENDING_EN defined:
  - The PENDING port exists and is combinational from the FIFO valid entries.
  - An addr-0 entry never sets a bit.
  - Bits clear in the cycle after the entry is popped.
- Not defined: the PENDING port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package regfile_pkg holds: REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, the wb_entry_t struct {addr, data}, and the ZERO_REG=0 constant.
- One sub-module, wb_fifo: a DEPTH-entry synchronous FIFO with async active-low reset, push/pop/full/empty outputs, and entry visibility for PENDING.
- Arbitration and the starvation counter live in the top level.

## Test plan
- Reset held with A_VALID=1, A_ADDR=5 -> WE3=0 throughout, A_READY=0. Release -> next cycle WE3=1, A3=5.
- A_VALID=1, A_ADDR=0, A_DATA=0xDEADBEEF -> A_READY=1, WE3=0; read of r0 stays 0.
- Four B pushes (r1..r4, data 0x11..0x44) with A idle -> writes r1..r4 on four consecutive edges in order, starting one cycle after the first push.
- Four B pushes back-to-back, then a fifth with A_VALID=1 continuously -> B_READY=0 on the fifth until a pop. After 8 A writes, one forced-drain cycle with A_READY=0, WE3=1, A3=r1.
- Simultaneous push of r7 and pop of r6 at occupancy 2 -> occupancy stays 2; PENDING[6] clears and PENDING[7] sets (with REGFILE_WRITER_PENDING_EN).
- RESETN pulsed low with 3 entries queued -> FIFO empty, PENDING=0, no WE3 pulse. Queued data is never written.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths, constants and write-back entry type
//
// Purpose: common definitions for the register-file write-back path.
// Ports:   none (package).

package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  // Register 0 is hardwired to zero; writes to it are dropped.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writer_wb_fifo.sv
// rtl/regfile_writer_wb_fifo.sv - DEPTH-entry synchronous FIFO for port B write-back results
//
// Purpose: buffers load/multiply results until a free write slot appears.
// Macro:   REGFILE_WRITER_PENDING_EN exposes every slot plus a per-slot valid mask.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_push, i_push_data  enqueue request and entry (ignored when full)
//   i_pop                dequeue request (ignored when empty)
//   o_head               oldest entry
//   o_full, o_empty      occupancy flags
//   o_entries, o_valid   all slots and their valid bits (PENDING build only)

import regfile_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  wb_entry_t i_push_data,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
`ifdef REGFILE_WRITER_PENDING_EN
  ,
  output wb_entry_t [DEPTH-1:0] o_entries,
  output logic      [DEPTH-1:0] o_valid
`endif
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef REGFILE_WRITER_PENDING_EN
  logic [DEPTH-1:0] r_valid;

  // Push and pop never hit the same slot: pop needs an entry, push needs a hole.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else begin
      if (w_pop)  r_valid[r_rd_ptr] <= 1'b0;
      if (w_push) r_valid[r_wr_ptr] <= 1'b1;
    end
  end

  assign o_entries = r_mem;
  assign o_valid   = r_valid;
`endif

endmodule

// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - write-back arbiter for the register file A3/WD3/WE3 port
//
// Purpose: merges a zero-latency ALU port (A) with a FIFO-buffered load/multiply
//          port (B) into one register write per cycle, with a starvation guard.
// Macro:   REGFILE_WRITER_PENDING_EN adds the PENDING output.
// Ports:
//   CLK, RESETN                     clock, asynchronous active-low reset
//   A_VALID/A_READY/A_ADDR/A_DATA   ALU result handshake
//   B_VALID/B_READY/B_ADDR/B_DATA   load/multiply result handshake
//   A3, WD3, WE3                    register file write port
//   PENDING                         per-register "queued in FIFO" mask (optional)

import regfile_pkg::*;

module regfile_writer #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  A_VALID,
  output logic                  A_READY,
  input  logic [REG_ADDR_W-1:0] A_ADDR,
  input  logic [REG_DATA_W-1:0] A_DATA,
  input  logic                  B_VALID,
  output logic                  B_READY,
  input  logic [REG_ADDR_W-1:0] B_ADDR,
  input  logic [REG_DATA_W-1:0] B_DATA,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [REG_DATA_W-1:0] WD3,
  output logic                  WE3
`ifdef REGFILE_WRITER_PENDING_EN
  ,
  output logic [NUM_REGS-1:0]   PENDING
`endif
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  wb_entry_t             w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_force;
  logic                  w_a_write;
  logic                  w_drain;
  logic                  w_push;
  logic [CW-1:0]         r_starve;
  logic [REG_ADDR_W-1:0] r_a3;
  logic [REG_DATA_W-1:0] r_wd3;

`ifdef REGFILE_WRITER_PENDING_EN
  wb_entry_t [DEPTH-1:0] w_entries;
  logic      [DEPTH-1:0] w_valid;
`endif

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (CLK),
    .i_rst_n     (RESETN),
    .i_push      (w_push),
    .i_push_data ({B_ADDR, B_DATA}),
    .i_pop       (w_drain),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
`ifdef REGFILE_WRITER_PENDING_EN
    ,
    .o_entries   (w_entries),
    .o_valid     (w_valid)
`endif
  );

  // Handshakes are gated by RESETN directly so nothing leaks out while reset is held.
  assign w_force   = ~w_empty & (r_starve == CW'(STARVE_MAX));
  assign A_READY   = RESETN & ~w_force;
  assign w_a_write = A_VALID & A_READY;
  assign w_drain   = RESETN & ~w_empty & ~w_a_write;
  assign B_READY   = RESETN & ~w_full;
  assign w_push    = B_VALID & B_READY;

  // In idle cycles A3/WD3 replay the last driven values to avoid needless toggling.
  always_comb begin
    WE3 = 1'b0;
    A3  = r_a3;
    WD3 = r_wd3;
    if (w_a_write) begin
      WE3 = (A_ADDR != ZERO_REG);
      A3  = A_ADDR;
      WD3 = A_DATA;
    end else if (w_drain) begin
      WE3 = (w_head.addr != ZERO_REG);
      A3  = w_head.addr;
      WD3 = w_head.data;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_a3  <= '0;
      r_wd3 <= '0;
    end else if (w_a_write || w_drain) begin
      r_a3  <= A3;
      r_wd3 <= WD3;
    end
  end

  // Counts port-A wins while the FIFO head waits; reaching STARVE_MAX forces the
  // following cycle to drain, and that pop clears it again.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_starve <= '0;
    end else if (w_drain || w_empty) begin
      r_starve <= '0;
    end else if (w_a_write) begin
      r_starve <= r_starve + CW'(1);
    end
  end

`ifdef REGFILE_WRITER_PENDING_EN
  always_comb begin
    PENDING = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_entries[i].addr != ZERO_REG)) begin
        PENDING[w_entries[i].addr] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writer.sv
// tb/tb_regfile_writer.sv - self-checking bench for regfile_writer
//
// Purpose: directed and random stimulus against a queue-based reference model.
// Macro:   REGFILE_WRITER_PENDING_EN also enables PENDING checks.
// Ports:   none (top-level bench).

module tb_regfile_writer;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        CLK;
  logic        RESETN;
  logic        A_VALID;
  logic        A_READY;
  logic [4:0]  A_ADDR;
  logic [31:0] A_DATA;
  logic        B_VALID;
  logic        B_READY;
  logic [4:0]  B_ADDR;
  logic [31:0] B_DATA;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
`ifdef REGFILE_WRITER_PENDING_EN
  logic [31:0] PENDING;
`endif

  regfile_writer #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .A_VALID (A_VALID),
    .A_READY (A_READY),
    .A_ADDR  (A_ADDR),
    .A_DATA  (A_DATA),
    .B_VALID (B_VALID),
    .B_READY (B_READY),
    .B_ADDR  (B_ADDR),
    .B_DATA  (B_DATA),
    .A3      (A3),
    .WD3     (WD3),
    .WE3     (WE3)
`ifdef REGFILE_WRITER_PENDING_EN
    ,
    .PENDING (PENDING)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Register file fed by the DUT write port, compared to the model at the end.
  logic [31:0] tb_rf    [32];
  logic [31:0] model_rf [32];

  always @(posedge CLK) begin
    if (WE3 === 1'b1) tb_rf[A3] <= WD3;
  end

  // Reference model: FIFO contents as queues, plus consecutive-loss count.
  logic [4:0]  q_addr [$];
  logic [31:0] q_data [$];
  int          starve;
  logic        last_aready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after negedge, check just after, advance model at posedge.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    bit          forced, a_wr, drain, b_rdy, was_empty;
    logic        exp_we;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd3;
    A_VALID = av; A_ADDR = aa; A_DATA = ad;
    B_VALID = bv; B_ADDR = ba; B_DATA = bd;
    #1;
    was_empty = (q_addr.size() == 0);
    forced    = !was_empty && (starve == STARVE_MAX);
    a_wr      = av && !forced;
    drain     = !a_wr && !was_empty;
    b_rdy     = (q_addr.size() < DEPTH);
    exp_we    = 1'b0;
    exp_a3    = '0;
    exp_wd3   = '0;
    if (a_wr) begin
      exp_we = (aa != 0); exp_a3 = aa; exp_wd3 = ad;
    end else if (drain) begin
      exp_we = (q_addr[0] != 0); exp_a3 = q_addr[0]; exp_wd3 = q_data[0];
    end
    last_aready = A_READY;
    chk("a_ready", A_READY, !forced);
    chk("b_ready", B_READY, b_rdy);
    chk("we3", WE3, exp_we);
    if (a_wr || drain) begin
      chk("a3", A3, exp_a3);
      chk("wd3", WD3, exp_wd3);
    end
`ifdef REGFILE_WRITER_PENDING_EN
    begin
      logic [31:0] pm;
      pm = '0;
      foreach (q_addr[k]) if (q_addr[k] != 0) pm[q_addr[k]] = 1'b1;
      chk("pending", PENDING, pm);
    end
`endif
    @(posedge CLK);
    if (exp_we) model_rf[exp_a3] = exp_wd3;
    if (drain || was_empty) starve = 0;
    else if (a_wr) starve++;
    if (drain) begin
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
    end
    if (bv && b_rdy) begin
      q_addr.push_back(ba);
      q_data.push_back(bd);
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int fc;
    int pushed;
    for (int i = 0; i < 32; i++) begin
      tb_rf[i]    = '0;
      model_rf[i] = '0;
    end
    starve  = 0;
    RESETN  = 1'b0;
    A_VALID = 1'b1; A_ADDR = 5'd5; A_DATA = 32'h0000_0055;
    B_VALID = 1'b0; B_ADDR = '0;   B_DATA = '0;

    // Reset held with a valid ALU write pending: nothing may reach the port.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      chk("rst_we3", WE3, 1'b0);
      chk("rst_a_ready", A_READY, 1'b0);
      chk("rst_b_ready", B_READY, 1'b0);
      chk("rst_a3", A3, 5'd0);
      chk("rst_wd3", WD3, 32'd0);
    end
    @(negedge CLK);
    RESETN = 1'b1;
    step(1'b1, 5'd5, 32'h0000_0055, 1'b0, 5'd0, 32'd0);
    chk("release_a3_seen", model_rf[5], 32'h0000_0055);

    // Write to r0 is accepted but discarded.
    step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);

    // Four port-B pushes with A idle drain in order, one cycle behind.
    for (int i = 1; i <= 4; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(i * 'h11));
    idle(2);
    chk("b_order_r4", model_rf[4], 32'h44);

    // Fill with A busy; the fifth push stalls until the forced drain.
    fc = 0;
    pushed = 0;
    for (int i = 1; i <= 14; i++) begin
      bit acc;
      acc = (q_addr.size() < DEPTH);
      step(1'b1, 5'(16 + (i % 8)), $urandom, pushed < 5,
           5'(pushed + 1), 32'(32'h100 + pushed));
      if (pushed < 5 && acc) pushed++;
      if (last_aready == 1'b0 && fc == 0) fc = i;
    end
    chk("forced_cycle", fc, 10);
    chk("fifth_pushed", pushed, 5);
    idle(6);

    // Simultaneous push r7 / pop r6 at occupancy 2.
    step(1'b1, 5'd20, 32'h1, 1'b1, 5'd6, 32'h66);
    step(1'b1, 5'd21, 32'h2, 1'b1, 5'd8, 32'h88);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
    chk("occupancy_2", q_addr.size(), 2);
`ifdef REGFILE_WRITER_PENDING_EN
    #1;
    chk("pend6_clear", PENDING[6], 1'b0);
    chk("pend7_set", PENDING[7], 1'b1);
`endif
    idle(4);

    // Reset with three entries queued: contents vanish, no write escapes.
    step(1'b1, 5'd22, 32'h3, 1'b1, 5'd9,  32'h9999);
    step(1'b1, 5'd23, 32'h4, 1'b1, 5'd10, 32'hAAAA);
    step(1'b1, 5'd24, 32'h5, 1'b1, 5'd11, 32'hBBBB);
    #2;
    RESETN = 1'b0;
    #1;
    chk("midrst_we3", WE3, 1'b0);
    chk("midrst_a_ready", A_READY, 1'b0);
`ifdef REGFILE_WRITER_PENDING_EN
    chk("midrst_pending", PENDING, 32'd0);
`endif
    @(posedge CLK);
    #1;
    chk("midrst_we3_edge", WE3, 1'b0);
    @(negedge CLK);
    RESETN = 1'b1;
    q_addr.delete();
    q_data.delete();
    starve = 0;
    idle(4);

    // Random traffic, A busy most of the time so the guard fires.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 10) < 8, 5'($urandom), $urandom,
           ($urandom % 3) != 0, 5'($urandom), $urandom);
    end
    idle(8);

    @(negedge CLK);
    for (int r = 0; r < 32; r++) chk($sformatf("rf_r%0d", r), tb_rf[r], model_rf[r]);
    chk("rf_r0_zero", tb_rf[0], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
